// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register and writeback mux for the 5-stage MIPS core.
//   This block latches the memory-stage result bundle and selects the value
//   written back to the register file. That value is the ALU result, the
//   load data, the link address (JAL) or the LUI immediate. The block also
//   owns the sticky halt flag and the retired-instruction counter.
//
// Ports
//   CLK, nRST      clock; asynchronous active-low reset
//   en             advance enable (already gated upstream by cache stalls)
//   flush          load a bubble this edge (wins over en)
//   in_valid       upstream slot holds a real instruction
//   in_regwen      instruction writes a register
//   in_wsel        destination register index
//   in_wbsrc       writeback source: 00 ALU, 01 load, 10 link, 11 LUI
//   in_aluout      ALU result
//   in_dmemload    load data from the dcache
//   in_npc         PC+4 of the instruction
//   in_imm16       immediate field
//   in_halt        instruction is HALT
//   WEN/wsel/wdat  register file write port
//   wb_valid       WB slot holds a real instruction (forwarding qualifier)
//   halt           sticky halt, set once HALT retires
//   retired        saturating count of retired valid instructions
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_regwen,
  input  logic [REG_W-1:0]  in_wsel,
  input  logic [1:0]        in_wbsrc,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [DATA_W-1:0] in_dmemload,
  input  logic [DATA_W-1:0] in_npc,
  input  logic [15:0]       in_imm16,
  input  logic              in_halt,
  output logic              WEN,
  output logic [REG_W-1:0]  wsel,
  output logic [DATA_W-1:0] wdat,
  output logic              wb_valid,
  output logic              halt,
  output logic [DATA_W-1:0] retired
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_LUI  = 2'b11
  } wbsrc_t;

  logic              valid_q;
  logic              regwen_q;
  logic [REG_W-1:0]  wsel_q;
  wbsrc_t            wbsrc_q;
  logic [DATA_W-1:0] aluout_q;
  logic [DATA_W-1:0] dmemload_q;
  logic [DATA_W-1:0] npc_q;
  logic [15:0]       imm16_q;
  logic              halt_q;
  logic [DATA_W-1:0] retired_q;

  // Pipeline register, halt flag and retired counter.
  // Once halt is set the whole stage freezes until reset, so nothing retires
  // after HALT. A flush only clears the control bits. The data fields are
  // don't-care in a bubble, so they are left alone.
  // The halt flag is set directly from the captured in_valid & in_halt. The
  // same edge therefore latches the HALT instruction and freezes the stage.
  // The counter saturates instead of wrapping, so a very long run can never
  // look as if it had retired only a few instructions.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid_q    <= 1'b0;
      regwen_q   <= 1'b0;
      wsel_q     <= '0;
      wbsrc_q    <= WB_ALU;
      aluout_q   <= '0;
      dmemload_q <= '0;
      npc_q      <= '0;
      imm16_q    <= '0;
      halt_q     <= 1'b0;
      retired_q  <= '0;
    end else if (halt_q) begin
      halt_q <= 1'b1;
    end else if (flush) begin
      valid_q  <= 1'b0;
      regwen_q <= 1'b0;
    end else if (en) begin
      valid_q    <= in_valid;
      regwen_q   <= in_regwen;
      wsel_q     <= in_wsel;
      wbsrc_q    <= wbsrc_t'(in_wbsrc);
      aluout_q   <= in_aluout;
      dmemload_q <= in_dmemload;
      npc_q      <= in_npc;
      imm16_q    <= in_imm16;
      halt_q     <= in_valid & in_halt;
      if (in_valid && (retired_q != '1)) begin
        retired_q <= retired_q + DATA_W'(1);
      end
    end
  end

  // Writeback source select. The mux reads only the latched fields, so the
  // register file never sees a combinational path from the MEM stage.
  // LUI puts the immediate in the upper half and zero-fills the lower half.
  always_comb begin
    wdat = aluout_q;
    case (wbsrc_q)
      WB_ALU:  wdat = aluout_q;
      WB_LOAD: wdat = dmemload_q;
      WB_LINK: wdat = npc_q;
      WB_LUI:  wdat = DATA_W'({imm16_q, 16'h0000});
      default: wdat = aluout_q;
    endcase
  end

  // Writes to $0 are dropped here, so upstream never has to special-case
  // them. A halted stage never writes. That also covers the HALT instruction
  // itself, because halt rises on the same edge that latches HALT.
  assign WEN      = valid_q & regwen_q & (wsel_q != '0) & ~halt_q;
  assign wsel     = wsel_q;
  assign wb_valid = valid_q & ~halt_q;
  assign halt     = halt_q;
  assign retired  = retired_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback mux for the 5-stage MIPS core.
- Latches the memory-stage result bundle and selects the writeback value: ALU result, load data, link address (JAL) or LUI immediate.
- Drives the register file write port (WEN/wsel/wdat).
- Also owns the sticky halt flag and the retired-instruction counter used by the testbench.

Parameters:
- DATA_W, 32, datapath and word width.
- REG_W, 5, register index width.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous, active-low reset.
- en  input  1  advance enable: capture the upstream bundle this edge (upstream gates this with ihit/dhit stall logic).
- flush  input  1  insert a bubble this edge; has priority over en.
- in_valid  input  1  upstream slot holds a real instruction.
- in_regwen  input  1  instruction writes a register.
- in_wsel  input  REG_W  destination register (31 for JAL, set upstream).
- in_wbsrc  input  2  writeback source: 00 = ALU, 01 = load, 10 = link, 11 = LUI.
- in_aluout  input  DATA_W  ALU result.
- in_dmemload  input  DATA_W  load data returned from dcache.
- in_npc  input  DATA_W  PC+4 of the instruction.
- in_imm16  input  16  immediate field.
- in_halt  input  1  instruction is HALT.
- WEN  output  1  register file write enable.
- wsel  output  REG_W  register file write index.
- wdat  output  DATA_W  register file write data.
- wb_valid  output  1  WB slot holds a real instruction (forwarding qualifier).
- halt  output  1  sticky halt; high once HALT has retired.
- retired  output  DATA_W  count of retired valid instructions.

Behaviour:
- Reset (nRST low, asynchronous):
  - All latched fields clear; wb_valid = 0, WEN = 0, wsel = 0, wdat = 0, halt = 0, retired = 0.
  - Reset asserted mid-operation discards the in-flight entry immediately. No write occurs on the following edge.
- Capture priority at each posedge, highest first:
  1. halt = 1: all fields frozen, wb_valid forced 0. en, flush and in_* are ignored.
  2. flush = 1: bubble loaded. valid = 0, regwen = 0, halt bit = 0; data fields are don't-care.
  3. en = 1: all in_* fields latched as-is.
  4. en = 0: hold all fields (stall). A held valid entry keeps WEN asserted. A rewrite of the same value is harmless and is legal.
- Latency:
  - One cycle from capture edge to WEN/wsel/wdat valid.
  - The register file writes on the following edge.
  - Total: an instruction captured at edge N is visible in the register file after edge N+1.
- Outputs are combinational from the latched fields only, never from in_*:
  - WEN = valid & regwen & (wsel != 0) & !halt. Writes to $0 are always suppressed.
  - wsel = latched wsel.
  - wdat by wbsrc: 00 = aluout; 01 = dmemload; 10 = npc; 11 = {imm16, 16'h0000}.
  - wb_valid = valid & !halt.
- Halt:
  - On a capture with in_valid & in_halt (not flushed), halt sets on that edge and stays set until reset.
  - The HALT instruction itself performs no register write (WEN = 0).
- Retired counter:
  - Increments by 1 on every edge where a valid entry is captured (en & !flush & in_valid & !halt).
  - A HALT counts as retired.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - flush and en together produce a bubble and no count.
  - flush together with in_halt sets no halt.
  - A stall (en = 0) on the halt edge leaves halt unchanged.

Test Plan:
1. Reset then capture ALU op: in_valid = 1, regwen = 1, wsel = 8, wbsrc = 00, aluout = 0x0000_1234, en = 1 -> next cycle WEN = 1, wsel = 8, wdat = 0x1234, retired = 1.
2. Source mux sweep:
   - wbsrc = 01 with dmemload = 0xDEAD_BEEF -> wdat = 0xDEADBEEF.
   - wbsrc = 10 with npc = 0x0000_0044, wsel = 31 -> wdat = 0x44, wsel = 31.
   - wbsrc = 11 with imm16 = 0xABCD -> wdat = 0xABCD0000.
3. $0 suppression: regwen = 1, wsel = 0, aluout = 5 -> WEN = 0, wb_valid = 1, retired increments.
4. Stall and flush:
   - Capture an op, then en = 0 for 3 cycles -> outputs hold constant and retired holds.
   - Then flush = 1 with en = 1 and in_valid = 1 -> WEN = 0, wb_valid = 0, no count.
5. Halt: capture in_halt = 1 -> halt = 1 next cycle and WEN = 0. A later valid regwen op with en = 1 causes no write, no count, and halt stays 1. Assert nRST -> halt = 0, retired = 0.
6. Saturation and async reset: preload the counter near max (force 0xFFFF_FFFE), retire 3 ops -> retired = 0xFFFFFFFF. Drop nRST between edges -> WEN falls to 0 immediately.
